// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - sprite OAM DMA: $4014 write stalls the CPU and copies a 256-byte page to OAMDATA.
// Optional OAM_DMA_ALIGN_EN inserts one ALIGN cycle when HALT falls on an odd cycle.
module oam_dma #(
  parameter logic [15:0] TRIGGER_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_write,
  input  logic [7:0]  cpu_d_out,
  output logic        ready,
  output logic        dma_active,
  output logic [15:0] bus_addr,
  output logic        bus_write,
  output logic [7:0]  bus_d_out,
  input  logic [7:0]  bus_d_in
);

  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

  state_t     state;
  logic [7:0] page;
  logic [7:0] count;
  logic       go_align;

`ifdef OAM_DMA_ALIGN_EN
  logic odd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) odd <= 1'b0;
    else       odd <= ~odd;
  end

  assign go_align = odd;
`else
  assign go_align = 1'b0;
`endif

  // Outputs are registered alongside the state they describe; bus_d_out
  // doubles as the byte latched during READ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      page       <= 8'h00;
      count      <= 8'h00;
      ready      <= 1'b1;
      dma_active <= 1'b0;
      bus_addr   <= 16'h0000;
      bus_write  <= 1'b0;
      bus_d_out  <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_write && cpu_addr == TRIGGER_ADDR) begin
            page  <= cpu_d_out;
            count <= 8'h00;
            state <= HALT;
            ready <= 1'b0;
          end
        end
        HALT: begin
          if (go_align) begin
            state <= ALIGN;
          end else begin
            state      <= READ;
            dma_active <= 1'b1;
            bus_addr   <= {page, count};
          end
        end
        ALIGN: begin
          state      <= READ;
          dma_active <= 1'b1;
          bus_addr   <= {page, count};
        end
        READ: begin
          state     <= WRITE;
          bus_addr  <= OAM_DATA_ADDR;
          bus_write <= 1'b1;
          bus_d_out <= bus_d_in;
        end
        WRITE: begin
          count     <= count + 8'h01;
          bus_write <= 1'b0;
          bus_d_out <= 8'h00;
          // The low address byte wraps inside the page; no carry into page.
          if (count == 8'hFF) begin
            state      <= IDLE;
            ready      <= 1'b1;
            dma_active <= 1'b0;
            bus_addr   <= 16'h0000;
          end else begin
            state    <= READ;
            bus_addr <= {page, count + 8'h01};
          end
        end
        default: begin
          state      <= IDLE;
          ready      <= 1'b1;
          dma_active <= 1'b0;
          bus_addr   <= 16'h0000;
          bus_write  <= 1'b0;
          bus_d_out  <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// tb/tb_oam_dma.sv - scoreboard bench for oam_dma with random memory, pages and trigger phases.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic        cpu_write;
  logic [7:0]  cpu_d_out;
  logic        ready;
  logic        dma_active;
  logic [15:0] bus_addr;
  logic        bus_write;
  logic [7:0]  bus_d_out;
  logic [7:0]  bus_d_in;

  oam_dma dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_write  (cpu_write),
    .cpu_d_out  (cpu_d_out),
    .ready      (ready),
    .dma_active (dma_active),
    .bus_addr   (bus_addr),
    .bus_write  (bus_write),
    .bus_d_out  (bus_d_out),
    .bus_d_in   (bus_d_in)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:65535];
  assign bus_d_in = mem[bus_addr];

  int          checks = 0;
  int          errors = 0;
  int          stall = 0;
  int          cyc = 0;
  logic [15:0] exp_addr_q [$];
  logic [7:0]  exp_data_q [$];
  int          exp_len_q  [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_nonempty(input string name, input int size);
    checks++;
    if (size == 0) begin
      errors++;
      $display("FAIL %s: got activity, expected none (queue empty)", name);
    end
  endtask

  // Posedges since reset release; the DUT's parity flop follows cyc[0].
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (reset) begin
      stall = 0;
    end else begin
      if (dma_active && !bus_write) begin
        check_nonempty("unexpected_read", exp_addr_q.size());
        if (exp_addr_q.size() != 0) check("read_addr", bus_addr, exp_addr_q.pop_front());
      end else if (dma_active && bus_write) begin
        check_nonempty("unexpected_write", exp_data_q.size());
        if (exp_data_q.size() != 0) begin
          check("write_addr", bus_addr, 16'h2004);
          check("write_data", bus_d_out, exp_data_q.pop_front());
        end
      end else begin
        check("idle_bus", {bus_addr, bus_write, bus_d_out}, 32'h0);
      end
      if (dma_active) check("active_ready", ready, 1'b0);
      if (!ready) begin
        stall++;
      end else if (stall != 0) begin
        check_nonempty("unexpected_stall", exp_len_q.size());
        if (exp_len_q.size() != 0) check("stall_len", stall, exp_len_q.pop_front());
        stall = 0;
      end
    end
  end

  // Caller sits at a negedge; the access is sampled at the next posedge.
  task automatic cpu_access(input logic [15:0] a, input logic w, input logic [7:0] d);
    cpu_addr = a; cpu_write = w; cpu_d_out = d;
    @(negedge clk);
    cpu_addr = 16'h0; cpu_write = 1'b0; cpu_d_out = 8'h0;
  endtask

  task automatic start(input logic [7:0] pg, output int a);
    logic [7:0] lo;
`ifdef OAM_DMA_ALIGN_EN
    a = (cyc + 1) % 2;
`else
    a = 0;
`endif
    for (int i = 0; i < 256; i++) begin
      lo = i[7:0];
      exp_addr_q.push_back({pg, lo});
      exp_data_q.push_back(mem[{pg, lo}]);
    end
    exp_len_q.push_back(513 + a);
    cpu_access(16'h4014, 1'b1, pg);
    check("halt_ready", ready, 1'b0);
    check("halt_active", dma_active, 1'b0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000 && !ready; i++) @(negedge clk);
    check("wait_idle_timeout", ready, 1'b1);
  endtask

  int a;
  logic [7:0] pg;

  initial begin
    reset = 1'b1; cpu_addr = 16'h0; cpu_write = 1'b0; cpu_d_out = 8'h0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1'b1);
    check("rst_active", dma_active, 1'b0);
    check("rst_bus", {bus_addr, bus_write, bus_d_out}, 32'h0);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rel_ready", ready, 1'b1);
    check("rel_bus", {bus_addr, bus_write, bus_d_out}, 32'h0);

    cpu_access(16'h4015, 1'b1, 8'h03);
    cpu_access(16'h4014, 1'b0, 8'h03);
    repeat (3) begin
      @(negedge clk);
      check("nontrig_ready", ready, 1'b1);
      check("nontrig_active", dma_active, 1'b0);
    end

    start(8'h02, a);
    wait_idle();

    for (int n = 0; n < 5; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      pg = 8'($urandom);
      start(pg, a);
      wait_idle();
    end

    // Page $FF wraps without carry; a second trigger at count $40 is ignored.
    start(8'hFF, a);
    repeat (130 + a) @(negedge clk);
    cpu_access(16'h4014, 1'b1, 8'h01);
    wait_idle();
    repeat (3) begin
      @(negedge clk);
      check("retrig_ready", ready, 1'b1);
    end

    // Trigger sampled on the same edge that ends the final WRITE is dropped.
    pg = 8'($urandom);
    start(pg, a);
    repeat (512 + a) @(negedge clk);
    check("final_write", bus_write, 1'b1);
    cpu_access(16'h4014, 1'b1, 8'h05);
    repeat (3) begin
      check("final_trig_ready", ready, 1'b1);
      check("final_trig_active", dma_active, 1'b0);
      @(negedge clk);
    end

    // Asynchronous reset during the WRITE of count $80.
    pg = 8'($urandom);
    start(pg, a);
    repeat (258 + a) @(negedge clk);
    check("pre_rst_write", bus_write, 1'b1);
    check("pre_rst_addr", bus_addr, 16'h2004);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_ready", ready, 1'b1);
    check("mid_rst_active", dma_active, 1'b0);
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_len_q.delete();
    stall = 0;
    @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    start(8'h03, a);
    wait_idle();

    repeat (2) @(negedge clk);
    check("left_reads", exp_addr_q.size(), 0);
    check("left_writes", exp_data_q.size(), 0);
    check("left_stalls", exp_len_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
